// File: rtl/io_handshake_port_if.sv
// Processor-side byte I/O handshake bundle: request strobe and byte from the
// processor, acknowledge, byte and interrupt back to it.
interface io_handshake_port_if #(
    parameter int d_width = 8
);
    logic               hs_out;
    logic [d_width-1:0] bus_out;
    logic               hs_in;
    logic [d_width-1:0] bus_in;
    logic               ext_int;

    modport master (
        output hs_out,
        output bus_out,
        input  hs_in,
        input  bus_in,
        input  ext_int
    );

    modport slave (
        input  hs_out,
        input  bus_out,
        output hs_in,
        output bus_in,
        output ext_int
    );
endinterface

// File: rtl/io_handshake_port.sv
// External-side responder for the 4-phase byte handshake: each exchange captures
// one processor byte into RX and hands one TX byte back, with host-side FIFOs.
module io_handshake_port #(
    parameter int d_width    = 8,
    parameter int depth      = 4,
    parameter int int_thresh = 1
) (
    input  logic               g_clk,
    input  logic               g_clr,
    io_handshake_port_if.slave cpu,
    input  logic [d_width-1:0] tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [d_width-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [7:0]         xfer_count
);
    localparam int AW = $clog2(depth);
    localparam logic [AW:0] THRESH = (AW+1)'(int_thresh);

    typedef enum logic {IDLE, ACK} state_t;

    state_t             state_q, state_d;
    logic               hs_in_q, hs_in_d;
    logic [d_width-1:0] bus_in_q, bus_in_d;
    logic               ext_int_q, ext_int_d;
    logic [7:0]         xfer_q, xfer_d;

    logic [d_width-1:0] tx_mem_q [depth];
    logic [d_width-1:0] rx_mem_q [depth];
    logic [AW:0]        tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;

    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        fire, tx_push, rx_pop;
    logic [AW:0] tx_cnt, tx_lvl_d;

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]) && (tx_wr_q[AW] != tx_rd_q[AW]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]) && (rx_wr_q[AW] != rx_rd_q[AW]);

    // A handshake pop frees a slot in the same cycle, so a full TX still accepts a push then.
    assign tx_ready = !tx_full || fire;
    assign tx_push  = tx_valid && tx_ready;
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_data  = rx_mem_q[rx_rd_q[AW-1:0]];

    assign tx_cnt   = tx_wr_q - tx_rd_q;
    assign tx_lvl_d = tx_cnt + (AW+1)'(tx_push) - (AW+1)'(fire);

    always_comb begin
        state_d   = state_q;
        hs_in_d   = hs_in_q;
        bus_in_d  = bus_in_q;
        xfer_d    = xfer_q;
        fire      = 1'b0;
        ext_int_d = (tx_lvl_d >= THRESH);
        unique case (state_q)
            IDLE: begin
                if (cpu.hs_out && !tx_empty && !rx_full) begin
                    fire     = 1'b1;
                    bus_in_d = tx_mem_q[tx_rd_q[AW-1:0]];
                    hs_in_d  = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK: begin
                if (!cpu.hs_out) begin
                    hs_in_d = 1'b0;
                    xfer_d  = xfer_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // fire feeds tx_lvl_d, so recompute now that the FSM has decided.
        ext_int_d = (tx_lvl_d >= THRESH);
    end

    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            state_q   <= IDLE;
            hs_in_q   <= 1'b0;
            bus_in_q  <= '0;
            ext_int_q <= 1'b0;
            xfer_q    <= '0;
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
        end else begin
            state_q   <= state_d;
            hs_in_q   <= hs_in_d;
            bus_in_q  <= bus_in_d;
            ext_int_q <= ext_int_d;
            xfer_q    <= xfer_d;
            if (tx_push) tx_wr_q <= tx_wr_q + (AW+1)'(1);
            if (fire)    tx_rd_q <= tx_rd_q + (AW+1)'(1);
            if (fire)    rx_wr_q <= rx_wr_q + (AW+1)'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge g_clk) begin
        if (tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= tx_data;
        if (fire)    rx_mem_q[rx_wr_q[AW-1:0]] <= cpu.bus_out;
    end

    assign cpu.hs_in   = hs_in_q;
    assign cpu.bus_in  = bus_in_q;
    assign cpu.ext_int = ext_int_q;
    assign xfer_count  = xfer_q;
endmodule

// File: tb/tb_io_handshake_port.sv
// Directed bench for io_handshake_port: a vector table for reset, single exchange
// and stall, then hand-written sequences for full, simultaneous and reset corners.
module tb_io_handshake_port;
    logic       g_clk = 1'b0;
    logic       g_clr;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] xfer_count;

    int checks = 0;
    int errors = 0;

    io_handshake_port_if #(.d_width(8)) cpu_if ();

    io_handshake_port #(.d_width(8), .depth(4), .int_thresh(1)) dut (
        .g_clk      (g_clk),
        .g_clr      (g_clr),
        .cpu        (cpu_if),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .xfer_count (xfer_count)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic       clr, hs;
        logic [7:0] bout, txd;
        logic       txv, rxr;
        logic       e_hs;
        logic [7:0] e_bus;
        logic       e_int, e_txr, e_rxv;
        logic [7:0] e_rxd;
        logic       c_rxd;
        logic [7:0] e_xfer;
    } vec_t;

    vec_t vt [20];

    function automatic vec_t mk(input logic clr, hs, input logic [7:0] bout, txd,
                                input logic txv, rxr, e_hs, input logic [7:0] e_bus,
                                input logic e_int, e_txr, e_rxv, input logic [7:0] e_rxd,
                                input logic c_rxd, input logic [7:0] e_xfer);
        vec_t v;
        v.clr = clr; v.hs = hs; v.bout = bout; v.txd = txd; v.txv = txv; v.rxr = rxr;
        v.e_hs = e_hs; v.e_bus = e_bus; v.e_int = e_int; v.e_txr = e_txr;
        v.e_rxv = e_rxv; v.e_rxd = e_rxd; v.c_rxd = c_rxd; v.e_xfer = e_xfer;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic xchg(input logic [7:0] bout, input logic [7:0] exp_bus, input logic rxr);
        cpu_if.hs_out  = 1'b1;
        cpu_if.bus_out = bout;
        rx_ready       = rxr;
        tick();
        chk("xchg_hs_in_up", cpu_if.hs_in, 1'b1);
        chk("xchg_bus_in", cpu_if.bus_in, exp_bus);
        rx_ready      = 1'b0;
        cpu_if.hs_out = 1'b0;
        tick();
        chk("xchg_hs_in_down", cpu_if.hs_in, 1'b0);
    endtask

    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic pop_check(input logic [7:0] exp);
        chk("rx_valid_pop", rx_valid, 1'b1);
        chk("rx_data_order", rx_data, exp);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        g_clr = 1'b1; cpu_if.hs_out = 1'b0; cpu_if.bus_out = '0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;

        //           clr hs bout   txd    txv rxr hs  bus    int txr rxv rxd    c  xfer
        vt[0]  = mk(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'd0);
        vt[1]  = mk(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'd0);
        vt[2]  = mk(0, 0, 8'h00, 8'hA5, 1, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 8'd0);
        vt[3]  = mk(0, 1, 8'h3C, 8'h00, 0, 0, 1, 8'hA5, 0, 1, 1, 8'h3C, 1, 8'd0);
        vt[4]  = mk(0, 0, 8'h3C, 8'h00, 0, 0, 0, 8'hA5, 0, 1, 1, 8'h3C, 1, 8'd1);
        vt[5]  = mk(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'hA5, 0, 1, 0, 8'h00, 0, 8'd1);
        for (int i = 6; i < 16; i++)
            vt[i] = mk(0, 1, 8'h55, 8'h00, 0, 0, 0, 8'hA5, 0, 1, 0, 8'h00, 0, 8'd1);
        vt[16] = mk(0, 1, 8'h55, 8'h11, 1, 0, 0, 8'hA5, 1, 1, 0, 8'h00, 0, 8'd1);
        vt[17] = mk(0, 1, 8'h55, 8'h00, 0, 0, 1, 8'h11, 0, 1, 1, 8'h55, 1, 8'd1);
        vt[18] = mk(0, 0, 8'h55, 8'h00, 0, 0, 0, 8'h11, 0, 1, 1, 8'h55, 1, 8'd2);
        vt[19] = mk(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h11, 0, 1, 0, 8'h00, 0, 8'd2);

        for (int i = 0; i < 20; i++) begin
            g_clr = vt[i].clr; cpu_if.hs_out = vt[i].hs; cpu_if.bus_out = vt[i].bout;
            tx_data = vt[i].txd; tx_valid = vt[i].txv; rx_ready = vt[i].rxr;
            tick();
            chk($sformatf("v%0d_hs_in", i), cpu_if.hs_in, vt[i].e_hs);
            chk($sformatf("v%0d_bus_in", i), cpu_if.bus_in, vt[i].e_bus);
            chk($sformatf("v%0d_ext_int", i), cpu_if.ext_int, vt[i].e_int);
            chk($sformatf("v%0d_tx_ready", i), tx_ready, vt[i].e_txr);
            chk($sformatf("v%0d_rx_valid", i), rx_valid, vt[i].e_rxv);
            if (vt[i].c_rxd) chk($sformatf("v%0d_rx_data", i), rx_data, vt[i].e_rxd);
            chk($sformatf("v%0d_xfer", i), xfer_count, vt[i].e_xfer);
        end
        cpu_if.hs_out = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;

        // TX full, fifth push dropped
        push(8'h10); push(8'h20); push(8'h30);
        chk("tx_ready_3", tx_ready, 1'b1);
        push(8'h40);
        chk("tx_ready_full", tx_ready, 1'b0);
        chk("ext_int_full", cpu_if.ext_int, 1'b1);
        push(8'hFF);
        chk("tx_ready_still_full", tx_ready, 1'b0);
        xchg(8'h01, 8'h10, 1'b0);
        xchg(8'h02, 8'h20, 1'b0);
        xchg(8'h03, 8'h30, 1'b0);
        xchg(8'h04, 8'h40, 1'b0);
        chk("ext_int_tx_empty", cpu_if.ext_int, 1'b0);
        chk("xfer_after_4", xfer_count, 8'd6);

        // RX full stalls the fifth exchange until the host pops one
        push(8'h50);
        cpu_if.hs_out = 1'b1; cpu_if.bus_out = 8'h05;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rx_full_stall", cpu_if.hs_in, 1'b0);
        end
        chk("rx_head_01", rx_data, 8'h01);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("stall_after_pop_edge", cpu_if.hs_in, 1'b0);
        tick();
        chk("stalled_completes", cpu_if.hs_in, 1'b1);
        chk("stalled_bus_in", cpu_if.bus_in, 8'h50);
        cpu_if.hs_out = 1'b0;
        tick();
        chk("xfer_after_5", xfer_count, 8'd7);
        pop_check(8'h02); pop_check(8'h03); pop_check(8'h04); pop_check(8'h05);
        chk("rx_drained", rx_valid, 1'b0);

        // push into full TX alongside a handshake pop
        push(8'h61); push(8'h62); push(8'h63); push(8'h64);
        chk("tx_full_again", tx_ready, 1'b0);
        cpu_if.hs_out = 1'b1; cpu_if.bus_out = 8'hA1;
        tx_data = 8'h65; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("simul_hs_in", cpu_if.hs_in, 1'b1);
        chk("simul_bus_in", cpu_if.bus_in, 8'h61);
        chk("simul_tx_still_full", tx_ready, 1'b0);
        cpu_if.hs_out = 1'b0;
        tick();
        // host RX pop in the same cycle as the handshake push
        xchg(8'hA2, 8'h62, 1'b1);
        chk("simul_rx_valid", rx_valid, 1'b1);
        chk("simul_rx_head", rx_data, 8'hA2);
        xchg(8'hA3, 8'h63, 1'b0);
        xchg(8'hA4, 8'h64, 1'b0);
        chk("ext_int_one_left", cpu_if.ext_int, 1'b1);
        xchg(8'hA5, 8'h65, 1'b0);
        chk("ext_int_zero_left", cpu_if.ext_int, 1'b0);
        chk("xfer_after_simul", xfer_count, 8'd12);
        pop_check(8'hA2); pop_check(8'hA3); pop_check(8'hA4); pop_check(8'hA5);
        chk("rx_empty_end", rx_valid, 1'b0);

        // reset in the middle of a handshake
        push(8'h70);
        cpu_if.hs_out = 1'b1; cpu_if.bus_out = 8'hB0;
        tick();
        chk("pre_reset_ack", cpu_if.hs_in, 1'b1);
        g_clr = 1'b1;
        tick();
        g_clr = 1'b0;
        chk("mid_rst_hs_in", cpu_if.hs_in, 1'b0);
        chk("mid_rst_bus_in", cpu_if.bus_in, 8'h00);
        chk("mid_rst_xfer", xfer_count, 8'd0);
        chk("mid_rst_rx_valid", rx_valid, 1'b0);
        chk("mid_rst_ext_int", cpu_if.ext_int, 1'b0);
        tick();
        chk("post_rst_idle", cpu_if.hs_in, 1'b0);
        push(8'h77);
        chk("post_rst_push_edge", cpu_if.hs_in, 1'b0);
        tick();
        chk("post_rst_hs_in", cpu_if.hs_in, 1'b1);
        chk("post_rst_bus_in", cpu_if.bus_in, 8'h77);
        cpu_if.hs_out = 1'b0;
        tick();
        chk("post_rst_xfer", xfer_count, 8'd1);
        chk("post_rst_rx_data", rx_data, 8'hB0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_handshake_port.md
Name: io_handshake_port

Overview:
- External-side responder for the processor's 4-phase byte I/O handshake.
- The processor drives bus_out/hs_out; this block drives bus_in/hs_in and raises ext_int.
- Each completed handshake is a full-duplex exchange: one byte is captured from the processor into the RX FIFO, and one byte is popped from the TX FIFO and presented to the processor.
- Host-side logic fills the TX FIFO and drains the RX FIFO through valid/ready streams. Processor and port share g_clk.

Parameters:
- d_width, 8, data byte width.
- depth, 4, entries per FIFO; power of 2, minimum 2.
- int_thresh, 1, TX occupancy at or above which ext_int asserts; 1..depth.

Ports:
- g_clk  input  1  clock; all state updates on rising edge.
- g_clr  input  1  synchronous, active-high reset.
- hs_out  input  1  processor request strobe.
- bus_out  input  d_width  processor output byte; valid while hs_out=1.
- hs_in  output  1  acknowledge to processor; registered.
- bus_in  output  d_width  byte to processor; registered.
- ext_int  output  1  processor interrupt request; registered.
- tx_data  input  d_width  host byte to enqueue for the processor.
- tx_valid  input  1  host push request.
- tx_ready  output  1  TX FIFO not full.
- rx_data  output  d_width  RX FIFO head; first-word fall-through.
- rx_valid  output  1  RX FIFO not empty.
- rx_ready  input  1  host pop request.
- xfer_count  output  8  completed exchanges; wraps 255->0.

Behaviour:
- Reset: synchronous active-high; one clock; reset is g_clk/g_clr.
  - On g_clr=1 at an edge: state=IDLE, hs_in=0, bus_in=0, ext_int=0, xfer_count=0.
  - Both FIFOs emptied, so tx_ready=1 and rx_valid=0.
  - Reset overrides every other event in that cycle, including mid-handshake. If hs_out is still 1 after reset, a new exchange is started normally once its conditions hold.
- FSM states:
  - IDLE: hs_in=0. At an edge with hs_out=1, TX not empty and RX not full:
    - Push bus_out into RX; pop TX head into bus_in; set hs_in=1; go to ACK.
    - Response latency is 1 cycle.
    - If any condition fails, remain in IDLE. The request stalls indefinitely; there is no timeout.
  - ACK: hs_in=1 and bus_in held.
    - At an edge with hs_out=0: hs_in=0, xfer_count+1, go to IDLE.
    - While hs_out stays 1, no further transfer occurs.
  - bus_in keeps its last value in IDLE; it is not cleared after a transfer.
- TX FIFO:
  - Push when tx_valid and tx_ready.
  - Push while full is ignored; tx_ready is already 0.
  - A push and a pop in the same cycle are both performed; the count is unchanged.
  - A pop when empty cannot occur because IDLE gates on not-empty.
- RX FIFO:
  - Pop when rx_valid and rx_ready.
  - rx_ready while empty has no effect.
  - Host pop and handshake push in the same cycle are both performed.
  - A push when full is prevented by the IDLE gating.
- FIFO pointers: log2(depth)+1 bits with wrap bit. Full = indices equal and wrap bits differ. Empty = pointers equal. Counts go 0..depth.
- ext_int: registered, computed from next-state TX occupancy >= int_thresh. It deasserts the cycle after the occupancy falls below the threshold.
- Ordering: bytes are delivered strictly FIFO in both directions; no reordering and no duplication.

Test Plan:
- Reset check: drive g_clr=1 for 2 cycles -> hs_in=0, bus_in=0x00, ext_int=0, tx_ready=1, rx_valid=0, xfer_count=0.
- Single exchange:
  - Push 0xA5 on TX; ext_int is 1 after that edge.
  - Hold bus_out=0x3C and raise hs_out -> next cycle hs_in=1, bus_in=0xA5, ext_int=0.
  - Drop hs_out -> next cycle hs_in=0, xfer_count=1, rx_valid=1, rx_data=0x3C.
- Stall on empty: with TX empty, hold hs_out=1 for 10 cycles -> hs_in stays 0. Push 0x11 -> hs_in=1 one cycle later with bus_in=0x11.
- Full boundaries (depth=4):
  - Push 4 TX bytes -> tx_ready=0; a fifth push of 0xFF is dropped.
  - Run 4 exchanges with bus_out 0x01..0x04 and no host pops -> a fifth hs_out stalls (RX full).
  - Pop one RX entry -> the stalled exchange completes.
  - RX yields 0x01..0x04 in order, then the fifth byte.
- Simultaneous events: host push into a full TX in the same cycle as a handshake pop -> both occur, TX count stays 4. Host RX pop in the same cycle as a handshake push -> count unchanged and order preserved.
- Reset mid-handshake: assert g_clr while in ACK with hs_out=1 -> hs_in=0 the next cycle, FIFOs empty. Keep hs_out=1 and push 0x77 -> a new exchange starts with bus_in=0x77 and xfer_count reads 1 after hs_out drops.
